// File: rtl/sc_microsequencer.sv
// sc_microsequencer: control-store address sequencer.
//   Selects the next micro-address (uPC) from the current microword's condition
//   field: sequential, flag/IR13 conditional jumps, unconditional jump, opcode
//   decode, call/return through a small LIFO, and a memory-ready wait.
//   Optional feature: define SC_MICROSEQ_CALL_STACK_EN to build the call/return
//   stack. Without it there is no stack storage: call acts as an unconditional
//   jump, return acts as next, and both error outputs are tied low.
// Ports:
//   SC_MicroSeq_CLOCK_50          clock, rising edge
//   SC_MicroSeq_RESET_InHigh      synchronous active-high reset
//   SC_MicroSeq_Cond_InBUS        microword condition field
//   SC_MicroSeq_JumpAddr_InBUS    microword jump/call target
//   SC_MicroSeq_IR_Ops_InBUS      IR opcode bits used for decode
//   SC_MicroSeq_IR13_In           IR bit 13
//   SC_MicroSeq_Flags_InBUS       ALU flags {N,Z,V,C}
//   SC_MicroSeq_FlagsWrite_InLow  active-low flag register load enable
//   SC_MicroSeq_Stall_InHigh      freeze uPC and stack this cycle
//   SC_MicroSeq_MemReady_InHigh   memory ready, sampled by the wait condition
//   SC_MicroSeq_Addr_OutBUS       registered uPC
//   SC_MicroSeq_Flags_OutBUS      registered {N,Z,V,C}
//   SC_MicroSeq_StackOvf_Out      sticky call-on-full error
//   SC_MicroSeq_StackUnf_Out      sticky return-on-empty error
//   SC_MicroSeq_Waiting_Out       combinational: uPC held by stall or wait
module sc_microsequencer #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned COND_WIDTH   = 4,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input  logic                    SC_MicroSeq_CLOCK_50,
  input  logic                    SC_MicroSeq_RESET_InHigh,
  input  logic [COND_WIDTH-1:0]   SC_MicroSeq_Cond_InBUS,
  input  logic [ADDR_WIDTH-1:0]   SC_MicroSeq_JumpAddr_InBUS,
  input  logic [OPCODE_WIDTH-1:0] SC_MicroSeq_IR_Ops_InBUS,
  input  logic                    SC_MicroSeq_IR13_In,
  input  logic [3:0]              SC_MicroSeq_Flags_InBUS,
  input  logic                    SC_MicroSeq_FlagsWrite_InLow,
  input  logic                    SC_MicroSeq_Stall_InHigh,
  input  logic                    SC_MicroSeq_MemReady_InHigh,
  output logic [ADDR_WIDTH-1:0]   SC_MicroSeq_Addr_OutBUS,
  output logic [3:0]              SC_MicroSeq_Flags_OutBUS,
  output logic                    SC_MicroSeq_StackOvf_Out,
  output logic                    SC_MicroSeq_StackUnf_Out,
  output logic                    SC_MicroSeq_Waiting_Out
);

  // Condition encodings
  localparam logic [COND_WIDTH-1:0] COND_JMP_N   = COND_WIDTH'(1);
  localparam logic [COND_WIDTH-1:0] COND_JMP_Z   = COND_WIDTH'(2);
  localparam logic [COND_WIDTH-1:0] COND_JMP_V   = COND_WIDTH'(3);
  localparam logic [COND_WIDTH-1:0] COND_JMP_C   = COND_WIDTH'(4);
  localparam logic [COND_WIDTH-1:0] COND_JMP_IR  = COND_WIDTH'(5);
  localparam logic [COND_WIDTH-1:0] COND_JMP     = COND_WIDTH'(6);
  localparam logic [COND_WIDTH-1:0] COND_DECODE  = COND_WIDTH'(7);
  localparam logic [COND_WIDTH-1:0] COND_CALL    = COND_WIDTH'(8);
  localparam logic [COND_WIDTH-1:0] COND_RETURN  = COND_WIDTH'(9);
  localparam logic [COND_WIDTH-1:0] COND_WAIT    = COND_WIDTH'(10);

  // Elaboration-time parameter sanity check
  if (ADDR_WIDTH < OPCODE_WIDTH + 3 || STACK_DEPTH < 2 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : gBadParams
    $error("sc_microsequencer: illegal parameter combination");
  end

  logic                  clk;
  logic                  rst;
  logic                  stall;
  logic                  memReady;
  logic [COND_WIDTH-1:0] cond;
  logic [ADDR_WIDTH-1:0] jumpAddr;

  assign clk      = SC_MicroSeq_CLOCK_50;
  assign rst      = SC_MicroSeq_RESET_InHigh;
  assign stall    = SC_MicroSeq_Stall_InHigh;
  assign memReady = SC_MicroSeq_MemReady_InHigh;
  assign cond     = SC_MicroSeq_Cond_InBUS;
  assign jumpAddr = SC_MicroSeq_JumpAddr_InBUS;

  logic [ADDR_WIDTH-1:0] uPc;
  logic [ADDR_WIDTH-1:0] uPcNext;
  logic [ADDR_WIDTH-1:0] uPcInc;
  logic [ADDR_WIDTH-1:0] decodeAddr;
  logic [3:0]            flagsQ;

  // Natural modulo-2^ADDR_WIDTH increment gives the all-ones -> 0 wrap
  assign uPcInc     = uPc + ADDR_WIDTH'(1);
  assign decodeAddr = ADDR_WIDTH'({1'b1, SC_MicroSeq_IR_Ops_InBUS, 2'b00});

`ifdef SC_MICROSEQ_CALL_STACK_EN
  localparam int unsigned PTR_WIDTH = $clog2(STACK_DEPTH);
  localparam int unsigned SP_WIDTH  = PTR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] stackMem [STACK_DEPTH];
  logic [SP_WIDTH-1:0]   sp;
  logic [PTR_WIDTH-1:0]  topIdx;
  logic                  stackFull;
  logic                  stackEmpty;
  logic                  push;
  logic                  pop;
  logic                  setOvf;
  logic                  setUnf;
  logic                  stackOvfQ;
  logic                  stackUnfQ;

  // sp counts occupied entries (0..STACK_DEPTH); its low bits index the next free slot
  assign stackFull  = (sp == SP_WIDTH'(STACK_DEPTH));
  assign stackEmpty = (sp == '0);
  assign topIdx     = sp[PTR_WIDTH-1:0] - PTR_WIDTH'(1);
`endif

  // Next-uPC selection; stall overrides every condition
  always_comb begin
    uPcNext = uPcInc;
`ifdef SC_MICROSEQ_CALL_STACK_EN
    push   = 1'b0;
    pop    = 1'b0;
    setOvf = 1'b0;
    setUnf = 1'b0;
`endif
    if (stall) begin
      uPcNext = uPc;
    end else begin
      case (cond)
        COND_JMP_N:  if (flagsQ[3])           uPcNext = jumpAddr;
        COND_JMP_Z:  if (flagsQ[2])           uPcNext = jumpAddr;
        COND_JMP_V:  if (flagsQ[1])           uPcNext = jumpAddr;
        COND_JMP_C:  if (flagsQ[0])           uPcNext = jumpAddr;
        COND_JMP_IR: if (SC_MicroSeq_IR13_In) uPcNext = jumpAddr;
        COND_JMP:    uPcNext = jumpAddr;
        COND_DECODE: uPcNext = decodeAddr;
        COND_CALL: begin
          uPcNext = jumpAddr;
`ifdef SC_MICROSEQ_CALL_STACK_EN
          // A call on a full stack still jumps but loses its return address
          if (stackFull) setOvf = 1'b1;
          else           push   = 1'b1;
`endif
        end
        COND_RETURN: begin
`ifdef SC_MICROSEQ_CALL_STACK_EN
          if (stackEmpty) begin
            setUnf = 1'b1;
          end else begin
            uPcNext = stackMem[topIdx];
            pop     = 1'b1;
          end
`endif
        end
        COND_WAIT: if (!memReady) uPcNext = uPc;
        default: ;
      endcase
    end
  end

  // uPC register
  always_ff @(posedge clk) begin
    if (rst) uPc <= '0;
    else     uPc <= uPcNext;
  end

  // Flag register loads regardless of stall; branches see the pre-load value
  always_ff @(posedge clk) begin
    if (rst)                               flagsQ <= 4'b0000;
    else if (!SC_MicroSeq_FlagsWrite_InLow) flagsQ <= SC_MicroSeq_Flags_InBUS;
  end

`ifdef SC_MICROSEQ_CALL_STACK_EN
  // Stack pointer and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      stackOvfQ <= 1'b0;
      stackUnfQ <= 1'b0;
    end else begin
      if (push)     sp <= sp + SP_WIDTH'(1);
      else if (pop) sp <= sp - SP_WIDTH'(1);
      if (setOvf) stackOvfQ <= 1'b1;
      if (setUnf) stackUnfQ <= 1'b1;
    end
  end

  // Return-address storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (!rst && push) stackMem[sp[PTR_WIDTH-1:0]] <= uPcInc;
  end

  assign SC_MicroSeq_StackOvf_Out = stackOvfQ;
  assign SC_MicroSeq_StackUnf_Out = stackUnfQ;
`else
  assign SC_MicroSeq_StackOvf_Out = 1'b0;
  assign SC_MicroSeq_StackUnf_Out = 1'b0;
`endif

  assign SC_MicroSeq_Addr_OutBUS  = uPc;
  assign SC_MicroSeq_Flags_OutBUS = flagsQ;
  assign SC_MicroSeq_Waiting_Out  = stall | ((cond == COND_WAIT) & ~memReady);

endmodule

// File: doc/sc_microsequencer.md
SC_MICROSEQUENCER -- requirements
Module: sc_microsequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: width of the micro-address (uPC) and the jump field.
REQ-002 Parameter OPCODE_WIDTH, default 8: width of the IR opcode bits used for decode; ADDR_WIDTH SHALL be >= OPCODE_WIDTH+3.
REQ-003 Parameter COND_WIDTH, default 4: width of the microword condition field.
REQ-004 Parameter STACK_DEPTH, default 4: number of entries in the micro-call return stack (power of two, >= 2).
REQ-005 SC_MicroSeq_CLOCK_50  in  1: the single clock; all state changes on its rising edge.
REQ-006 SC_MicroSeq_RESET_InHigh  in  1: reset, synchronous and active-high.
REQ-007 SC_MicroSeq_Cond_InBUS  in  COND_WIDTH: condition field of the current microword.
REQ-008 SC_MicroSeq_JumpAddr_InBUS  in  ADDR_WIDTH: jump/call target of the current microword.
REQ-009 SC_MicroSeq_IR_Ops_InBUS  in  OPCODE_WIDTH: opcode bits from IR.
REQ-010 SC_MicroSeq_IR13_In  in  1: IR bit 13.
REQ-011 SC_MicroSeq_Flags_InBUS  in  4: ALU flags {N,Z,V,C}.
REQ-012 SC_MicroSeq_FlagsWrite_InLow  in  1: active-low flag-register load enable.
REQ-013 SC_MicroSeq_Stall_InHigh  in  1: freeze sequencing for this cycle.
REQ-014 SC_MicroSeq_MemReady_InHigh  in  1: main-memory ready, sampled by the wait condition.
REQ-015 SC_MicroSeq_Addr_OutBUS  out  ADDR_WIDTH: registered uPC, drives control-store address.
REQ-016 SC_MicroSeq_Flags_OutBUS  out  4: registered {N,Z,V,C}.
REQ-017 SC_MicroSeq_StackOvf_Out / SC_MicroSeq_StackUnf_Out  out  1 each: sticky stack overflow / underflow errors.
REQ-018 SC_MicroSeq_Waiting_Out  out  1: high while uPC is held by the wait condition or stall.

Function
REQ-019 Flag register SHALL load SC_MicroSeq_Flags_InBUS on every edge where FlagsWrite_InLow=0, independent of stall; branch decisions SHALL use the registered value (pre-update).
REQ-020 Next uPC by Cond: 0 next (uPC+1); 1 jump if N; 2 jump if Z; 3 jump if V; 4 jump if C; 5 jump if IR13; 6 jump always; 7 decode; 8 call; 9 return; 10 wait; 11-15 next.
REQ-021 Not-taken conditional jumps SHALL select uPC+1.
REQ-022 Decode address SHALL be {1'b1, opcode, 2'b00} zero-extended at the MSB side to ADDR_WIDTH.
REQ-023 uPC+1 SHALL wrap from all-ones to 0.
REQ-024 Call SHALL push uPC+1 and load JumpAddr; return SHALL pop top entry into uPC; stack is LIFO.
REQ-025 Call with stack full SHALL still jump, SHALL not modify the stack, and SHALL set StackOvf.
REQ-026 Return with stack empty SHALL select uPC+1 and set StackUnf.
REQ-027 Wait SHALL hold uPC while MemReady=0 and select uPC+1 on a cycle where MemReady=1.
REQ-028 Stall=1 SHALL hold uPC and stack unchanged regardless of Cond; stall has priority over all conditions.
REQ-029 Waiting_Out SHALL be combinational: Stall | (Cond==10 & ~MemReady).
REQ-030 uPC update latency SHALL be one clock: Addr_OutBUS reflects the decision made in the prior cycle.

Reset
REQ-031 On reset edge: uPC=0, flags=0000, stack pointer=empty, StackOvf=0, StackUnf=0; reset overrides stall, flag write and all conditions.
REQ-032 StackOvf/StackUnf SHALL clear only on reset.

Configuration
REQ-033 Macro SC_MICROSEQ_CALL_STACK_EN defined: call/return stack per REQ-024..026.
REQ-034 Macro undefined: no stack storage; call behaves as jump always, return as next, StackOvf/StackUnf tied 0.

Verification
REQ-035 Reset then Cond=0 for 3 clocks -> Addr 0,1,2,3; at Addr=2047 Cond=0 -> Addr 0.
REQ-036 Flags written 0100 with FlagsWrite=0, next cycle Cond=2 JumpAddr=0x155 -> Addr 0x155; Cond=1 same -> Addr+1.
REQ-037 Opcode 0x81, Cond=7 -> Addr 0x604.
REQ-038 At Addr 0x10 Cond=8 JumpAddr=0x200, then Cond=9 -> Addr 0x200 then 0x11; 5 nested calls (depth 4) -> StackOvf=1, fifth call still jumps.
REQ-039 Cond=10 with MemReady=0 for 3 clocks -> Addr held, Waiting=1; MemReady=1 -> Addr+1; Stall=1 with Cond=6 -> Addr held.
REQ-040 Empty stack, Cond=9 at Addr 0x30 -> Addr 0x31, StackUnf=1 until reset asserted mid-sequence -> all outputs zero next edge.
